// File: rtl/debug_pkg.sv
// Shared definitions for the serial debug path:
// FSM encoding, ASCII codes and UART timing defaults.
package debug_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FETCH,
      ST_ISSUE,
      ST_ACK
   } state_t;

   localparam logic [7:0] LF    = 8'h0A;
   localparam logic [7:0] CR    = 8'h0D;
   localparam logic [7:0] SPACE = 8'h20;

   localparam int CLK_FREQ = 25000000;
   localparam int BAUD     = 115200;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first request
// after the last-served index, wrapping modulo NUM_REQ.
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    last,
   output logic               any,
   output logic [ID_W-1:0]    gnt_id,
   output logic [NUM_REQ-1:0] gnt_oh
);

   int idx;

   always_comb begin
      any    = 1'b0;
      gnt_id = '0;
      gnt_oh = '0;
      idx    = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = (int'(last) + k) % NUM_REQ;
         if (!any && req[idx]) begin
            any         = 1'b1;
            gnt_id      = idx[ID_W-1:0];
            gnt_oh[idx] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx among NUM_REQ message sources,
// one whole message per grant, with a stall timeout.
module uart_tx_arbiter
   import debug_pkg::*;
#(
   parameter int NUM_REQ      = 4,
   parameter int ID_W         = 2,
   parameter int TIMEOUT_CLKS = 65535
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [8*NUM_REQ-1:0] req_data,
   input  logic [NUM_REQ-1:0]   req_last,
   output logic [NUM_REQ-1:0]   req_ready,
   output logic [7:0]           tx_data,
   output logic                 tx_send,
   input  logic                 tx_busy,
   output logic                 grant_active,
   output logic [ID_W-1:0]      grant_id,
   output logic                 timeout_evt
);

   localparam logic [15:0] TMAX = 16'(TIMEOUT_CLKS - 1);

   state_t               state;
   logic [ID_W-1:0]      rr_last;
   logic [NUM_REQ-1:0]   grant_oh;
   logic [15:0]          tcnt;
   logic                 last_q;

   logic                 arb_any;
   logic [ID_W-1:0]      arb_id;
   logic [NUM_REQ-1:0]   arb_oh;

   logic                 gnt_valid;
   logic                 gnt_last;
   logic [7:0]           gnt_data;
   logic                 fetch_ok;
   logic                 hs;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_arb (
      .req    (req_valid),
      .last   (rr_last),
      .any    (arb_any),
      .gnt_id (arb_id),
      .gnt_oh (arb_oh)
   );

   always_comb begin
      gnt_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_oh[i]) gnt_data = gnt_data | req_data[8*i +: 8];
      end
   end

   assign gnt_valid = |(req_valid & grant_oh);
   assign gnt_last  = |(req_last & grant_oh);
   assign fetch_ok  = (state == ST_FETCH) && !tx_busy;
   assign req_ready = fetch_ok ? grant_oh : '0;
   assign hs        = fetch_ok && gnt_valid;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         rr_last      <= ID_W'(NUM_REQ - 1);
         grant_oh     <= '0;
         grant_id     <= '0;
         grant_active <= 1'b0;
         tcnt         <= '0;
         last_q       <= 1'b0;
         tx_data      <= '0;
         tx_send      <= 1'b0;
         timeout_evt  <= 1'b0;
      end else begin
         tx_send     <= 1'b0;
         timeout_evt <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (arb_any) begin
                  grant_id     <= arb_id;
                  grant_oh     <= arb_oh;
                  grant_active <= 1'b1;
                  tcnt         <= '0;
                  state        <= ST_FETCH;
               end
            end
            ST_FETCH: begin
               if (hs) begin
                  tx_data <= gnt_data;
                  last_q  <= gnt_last;
                  tcnt    <= '0;
                  tx_send <= 1'b1;
                  state   <= ST_ISSUE;
               end else if (!gnt_valid) begin
                  // only a silent source counts toward revocation
                  if (tcnt == TMAX) begin
                     timeout_evt  <= 1'b1;
                     grant_active <= 1'b0;
                     rr_last      <= grant_id;
                     tcnt         <= '0;
                     state        <= ST_IDLE;
                  end else begin
                     tcnt <= tcnt + 16'd1;
                  end
               end
            end
            ST_ISSUE: begin
               state <= ST_ACK;
            end
            ST_ACK: begin
               if (tx_busy) begin
                  if (last_q) begin
                     grant_active <= 1'b0;
                     rr_last      <= grant_id;
                     state        <= ST_IDLE;
                  end else begin
                     state <= ST_FETCH;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a behavioural
// uart_tx and serial-line decoder attached.
module tb_uart_tx_arbiter;
   import debug_pkg::*;

   localparam int N = 4;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [N-1:0]   req_valid;
   logic [8*N-1:0] req_data;
   logic [N-1:0]   req_last;
   logic [N-1:0]   req_ready;
   logic [7:0]     tx_data;
   logic           tx_send;
   logic           tx_busy;
   logic           grant_active;
   logic [1:0]     grant_id;
   logic           timeout_evt;

   always #20 clk = ~clk;

   uart_tx_arbiter #(
      .NUM_REQ      (N),
      .ID_W         (2),
      .TIMEOUT_CLKS (16)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_data     (req_data),
      .req_last     (req_last),
      .req_ready    (req_ready),
      .tx_data      (tx_data),
      .tx_send      (tx_send),
      .tx_busy      (tx_busy),
      .grant_active (grant_active),
      .grant_id     (grant_id),
      .timeout_evt  (timeout_evt)
   );

   // per-source byte queues: {last, data}
   logic [8:0] mem [N][64];
   int         head [N];
   int         tail [N];
   logic       flush = 1'b0;

   always_comb begin
      req_valid = '0;
      req_data  = '0;
      req_last  = '0;
      for (int i = 0; i < N; i++) begin
         req_valid[i]      = (head[i] != tail[i]);
         req_data[8*i +: 8] = mem[i][head[i]][7:0];
         req_last[i]       = mem[i][head[i]][8];
      end
   end

   int         n_acc = 0;
   int         acc_src [64];
   logic [7:0] acc_dat [64];
   logic       acc_last [64];

   always @(posedge clk) begin
      for (int i = 0; i < N; i++) begin
         if (flush) begin
            head[i] <= tail[i];
         end else if (rst_n && req_valid[i] && req_ready[i]) begin
            head[i]         <= head[i] + 1;
            acc_src[n_acc]  <= i;
            acc_dat[n_acc]  <= req_data[8*i +: 8];
            acc_last[n_acc] <= req_last[i];
            n_acc           <= n_acc + 1;
         end
      end
   end

   // behavioural uart_tx: busy rises the cycle after send
   int         bit_clks = 217;
   logic       force_busy = 1'b0;
   logic       m_busy = 1'b0;
   logic       txd = 1'b1;
   logic [9:0] frame = '1;
   int         mbit = 0;
   int         msub = 0;
   int         n_send = 0;

   assign tx_busy = m_busy | force_busy;

   always @(posedge clk) begin
      if (tx_send) n_send <= n_send + 1;
      if (!m_busy) begin
         txd <= 1'b1;
         if (tx_send) begin
            m_busy <= 1'b1;
            frame  <= {1'b1, tx_data, 1'b0};
            mbit   <= 0;
            msub   <= 0;
            txd    <= 1'b0;
         end
      end else if (msub == bit_clks - 1) begin
         msub <= 0;
         if (mbit == 9) begin
            m_busy <= 1'b0;
            txd    <= 1'b1;
         end else begin
            mbit <= mbit + 1;
            txd  <= frame[mbit+1];
         end
      end else begin
         msub <= msub + 1;
      end
   end

   logic       rx_act = 1'b0;
   int         rx_cnt = 0;
   int         rx_n = 0;
   logic [7:0] rx_sh = '0;
   logic [7:0] rx_log [32];
   int         n_rx = 0;

   always @(posedge clk) begin
      if (!rx_act) begin
         if (!txd) begin
            rx_act <= 1'b1;
            rx_cnt <= bit_clks + bit_clks / 2 - 1;
            rx_n   <= 0;
         end
      end else if (rx_cnt == 0) begin
         rx_cnt <= bit_clks - 1;
         rx_n   <= rx_n + 1;
         if (rx_n < 8) begin
            rx_sh <= {txd, rx_sh[7:1]};
         end else begin
            rx_act       <= 1'b0;
            rx_log[n_rx] <= rx_sh;
            n_rx         <= n_rx + 1;
         end
      end else begin
         rx_cnt <= rx_cnt - 1;
      end
   end

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push(input int s, input logic [7:0] d, input logic l);
      mem[s][tail[s]] = {l, d};
      tail[s] = tail[s] + 1;
   endtask

   function automatic logic qempty();
      logic e;
      e = 1'b1;
      for (int i = 0; i < N; i++) if (head[i] != tail[i]) e = 1'b0;
      return e;
   endfunction

   task automatic drain(input string tag, input int maxc);
      int c;
      c = 0;
      while (c < maxc && !(!grant_active && !tx_busy && qempty())) begin
         tick(1);
         c++;
      end
      check({tag, "_drain"}, 32'(c < maxc), 1);
   endtask

   function automatic logic [31:0] sd(input int s, input logic [7:0] d);
      return 32'(s) * 256 + 32'(d);
   endfunction

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int c, base, first, cnt0, cnt3, s0, exp_s;
      logic bad, seen, ga;
      logic [7:0] exp_d;

      rst_n = 1'b0;
      tick(2);
      check("rst_send", 32'(tx_send), 0);
      check("rst_data", 32'(tx_data), 0);
      check("rst_gact", 32'(grant_active), 0);
      check("rst_gid", 32'(grant_id), 0);
      check("rst_ready", 32'(req_ready), 0);
      check("rst_evt", 32'(timeout_evt), 0);
      rst_n = 1'b1;

      // basic "OK\n" from source 0 at 217 clk/bit
      push(0, 8'h4F, 1'b0);
      push(0, 8'h4B, 1'b0);
      push(0, LF, 1'b1);
      bad = 1'b0;
      seen = 1'b0;
      c = 0;
      tick(1);
      while (c < 20000 && (grant_active || !seen)) begin
         if (grant_active) begin
            seen = 1'b1;
            if (grant_id != 2'd0) bad = 1'b1;
         end
         tick(1);
         c++;
      end
      check("basic_end", 32'(seen && c < 20000), 1);
      check("basic_gid", 32'(bad), 0);
      check("basic_nacc", 32'(n_acc), 3);
      c = 0;
      while (c < 5000 && n_rx < 3) begin
         tick(1);
         c++;
      end
      check("basic_nrx", 32'(n_rx), 3);
      check("basic_rx0", 32'(rx_log[0]), 32'h4F);
      check("basic_rx1", 32'(rx_log[1]), 32'h4B);
      check("basic_rx2", 32'(rx_log[2]), 32'h0A);
      drain("basic", 5000);
      tick(2);
      bit_clks = 4;

      // contention between sources 1 and 2, plus first-byte latency
      base = n_acc;
      push(1, 8'h41, 1'b0);
      push(1, 8'h42, 1'b1);
      push(2, 8'h43, 1'b0);
      push(2, 8'h44, 1'b1);
      tick(1);
      check("lat_gact", 32'(grant_active), 1);
      check("lat_gid", 32'(grant_id), 1);
      check("lat_ready", 32'(req_ready), 32'b0010);
      tick(1);
      check("lat_send", 32'(tx_send), 1);
      check("lat_data", 32'(tx_data), 32'h41);
      tick(1);
      check("lat_busy", 32'(tx_busy), 1);
      check("lat_send_pulse", 32'(tx_send), 0);
      drain("cont", 1000);
      check("cont_b0", sd(acc_src[base], acc_dat[base]), sd(1, 8'h41));
      check("cont_b1", sd(acc_src[base+1], acc_dat[base+1]), sd(1, 8'h42));
      check("cont_b2", sd(acc_src[base+2], acc_dat[base+2]), sd(2, 8'h43));
      check("cont_b3", sd(acc_src[base+3], acc_dat[base+3]), sd(2, 8'h44));

      // round-robin between sources 0 and 3 from a fresh reset
      rst_n = 1'b0;
      tick(1);
      rst_n = 1'b1;
      base = n_acc;
      for (int m = 0; m < 4; m++) begin
         push(0, 8'(8'h10 + m), 1'b0);
         push(0, 8'(8'h20 + m), 1'b1);
         push(3, 8'(8'h30 + m), 1'b0);
         push(3, 8'(8'h40 + m), 1'b1);
      end
      drain("rr", 3000);
      cnt0 = 0;
      cnt3 = 0;
      for (int j = 0; j < 16; j++) begin
         exp_s = ((j / 2) % 2 == 0) ? 0 : 3;
         exp_d = (exp_s == 0) ? ((j % 2 == 1) ? 8'h20 : 8'h10)
                              : ((j % 2 == 1) ? 8'h40 : 8'h30);
         exp_d = exp_d + 8'(j / 4);
         check($sformatf("rr_b%0d", j),
               sd(acc_src[base+j], acc_dat[base+j]), sd(exp_s, exp_d));
         if (acc_last[base+j] && acc_src[base+j] == 0) cnt0++;
         if (acc_last[base+j] && acc_src[base+j] == 3) cnt3++;
      end
      check("rr_cnt0", 32'(cnt0), 4);
      check("rr_cnt3", 32'(cnt3), 4);

      // timeout: source 2 stalls mid-message, source 0 waits
      base = n_acc;
      push(2, 8'h58, 1'b0);
      tick(1);
      check("to_gact", 32'(grant_active), 1);
      check("to_gid", 32'(grant_id), 2);
      push(0, 8'h5A, 1'b1);
      first = -1;
      ga = 1'b1;
      for (int k = 2; k <= 40 && first < 0; k++) begin
         tick(1);
         if (timeout_evt) begin
            first = k;
            ga = grant_active;
         end
      end
      check("to_latency", 32'(first), 20);
      check("to_drop", 32'(ga), 0);
      tick(1);
      check("to_pulse", 32'(timeout_evt), 0);
      check("to_next_gact", 32'(grant_active), 1);
      check("to_next_gid", 32'(grant_id), 0);
      drain("to", 1000);
      check("to_nacc", 32'(n_acc - base), 2);
      check("to_b1", sd(acc_src[base+1], acc_dat[base+1]), sd(0, 8'h5A));

      // single byte while uart is held busy
      force_busy = 1'b1;
      push(3, 8'h51, 1'b1);
      tick(1);
      check("hold_gact", 32'(grant_active), 1);
      check("hold_gid", 32'(grant_id), 3);
      s0 = n_send;
      bad = 1'b0;
      for (int k = 0; k < 99; k++) begin
         if (req_ready != '0) bad = 1'b1;
         tick(1);
      end
      check("hold_ready", 32'(bad), 0);
      check("hold_sends", 32'(n_send - s0), 0);
      force_busy = 1'b0;
      tick(100);
      check("hold_one_send", 32'(n_send - s0), 1);
      drain("hold", 1000);

      // reset during ACK of byte 2 of 4
      base = n_acc;
      push(1, 8'h61, 1'b0);
      push(1, 8'h62, 1'b0);
      push(1, 8'h63, 1'b0);
      push(1, 8'h64, 1'b1);
      c = 0;
      while (c < 500 && n_acc < base + 2) begin
         tick(1);
         c++;
      end
      check("mid_reach", 32'(n_acc - base), 2);
      tick(1);
      rst_n = 1'b0;
      flush = 1'b1;
      tick(1);
      rst_n = 1'b1;
      flush = 1'b0;
      check("mid_send", 32'(tx_send), 0);
      check("mid_data", 32'(tx_data), 0);
      check("mid_gact", 32'(grant_active), 0);
      check("mid_gid", 32'(grant_id), 0);
      check("mid_ready", 32'(req_ready), 0);
      check("mid_evt", 32'(timeout_evt), 0);
      push(0, 8'h6D, 1'b1);
      push(2, 8'h6E, 1'b1);
      tick(1);
      check("mid_win_gact", 32'(grant_active), 1);
      check("mid_win_gid", 32'(grant_id), 0);
      drain("mid", 1000);
      check("mid_nacc", 32'(n_acc - base), 4);
      check("mid_b2", sd(acc_src[base+2], acc_dat[base+2]), sd(0, 8'h6D));
      check("mid_b3", sd(acc_src[base+3], acc_dat[base+3]), sd(2, 8'h6E));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
